// File: rtl/vector_scalar_reduce.sv
// vector_scalar_reduce: reduces each N-lane beat to a scalar (sum, max or
// frame-accumulated sum) through a registered pairwise tree, or passes the
// whole vector through (bypass). Result sits in lane 0 of an N-lane bus.
// Firmware ops are loaded per chain over the shared configId/configData stream.
module vector_scalar_reduce #(
  parameter int unsigned              N                   = 8,
  parameter int unsigned              DATA_WIDTH          = 32,
  parameter int unsigned              MAX_CHAINS          = 4,
  parameter logic [7:0]               PERSONAL_CONFIG_ID  = 8'd0,
  parameter int unsigned              DATA_TYPE           = 0,
  parameter logic [8*MAX_CHAINS-1:0]  INITIAL_FIRMWARE_OP = '0,
  localparam int unsigned             CW = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              tracing,
  input  logic                              valid_in,
  input  logic [1:0]                        eof_in,
  input  logic [1:0]                        bof_in,
  input  logic [CW-1:0]                     chainId_in,
  input  logic [7:0]                        configId,
  input  logic [7:0]                        configData,
  input  logic [N-1:0][DATA_WIDTH-1:0]      vector_in,
  output logic [N-1:0][DATA_WIDTH-1:0]      vector_out,
  output logic                              valid_out,
  output logic [1:0]                        eof_out,
  output logic [1:0]                        bof_out,
  output logic [CW-1:0]                     chainId_out
);

  localparam int unsigned    LOG2N       = $clog2(N);
  localparam int unsigned    BCW         = $clog2(MAX_CHAINS + 1);
  localparam logic [BCW-1:0] CHAIN_LIMIT = BCW'(MAX_CHAINS);

  typedef logic [N-1:0][DATA_WIDTH-1:0] vec_t;
  typedef enum logic [1:0] {
    OP_BYPASS = 2'd0,
    OP_SUM    = 2'd1,
    OP_MAX    = 2'd2,
    OP_FRAME  = 2'd3
  } op_t;

  logic [7:0]            firmware_op [MAX_CHAINS];
  logic [BCW-1:0]        byte_counter;
  logic [DATA_WIDTH-1:0] acc;

  // Tree level k holds N>>k reduced lanes; a bypass beat keeps all N lanes
  // and simply shifts through the same registers.
  vec_t                  lvl      [1:LOG2N];
  vec_t                  lvl_next [1:LOG2N];
  logic                  valid_q  [1:LOG2N];
  op_t                   op_q     [1:LOG2N];
  logic [1:0]            eof_q    [1:LOG2N];
  logic [1:0]            bof_q    [1:LOG2N];
  logic [CW-1:0]         chain_q  [1:LOG2N];

  logic [7:0]            op_byte;
  op_t                   op_in;
  logic                  accept;
  logic [DATA_WIDTH-1:0] acc_next;
  vec_t                  result;
  logic                  emit;

  function automatic logic [DATA_WIDTH-1:0] max2(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    logic a_wins;
    if (DATA_TYPE == 1) a_wins = ($signed(a) >= $signed(b));
    else                a_wins = (a >= b);
    return a_wins ? a : b;
  endfunction

  function automatic vec_t reduce_level(input vec_t v, input op_t op, input int unsigned half);
    vec_t r;
    r = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (op == OP_BYPASS)
        r[j] = v[j];
      else if (j < half)
        r[j] = (op == OP_MAX) ? max2(v[2*j], v[2*j+1]) : v[2*j] + v[2*j+1];
    end
    return r;
  endfunction

  // Per-beat op lookup; out-of-range firmware bytes fall back to bypass
  always_comb begin
    op_byte = firmware_op[chainId_in];
    op_in   = (op_byte > 8'd3) ? OP_BYPASS : op_t'(op_byte[1:0]);
    accept  = valid_in & tracing;
  end

  // Next value of every tree level
  always_comb begin
    lvl_next[1] = reduce_level(vector_in, op_in, N >> 1);
    for (int unsigned k = 2; k <= LOG2N; k++)
      lvl_next[k] = reduce_level(lvl[k-1], op_q[k-1], N >> k);
  end

  // Tree data and sideband registers (validity is qualified by valid_q)
  always_ff @(posedge clk) begin
    lvl        <= lvl_next;
    op_q[1]    <= op_in;
    eof_q[1]   <= eof_in;
    bof_q[1]   <= bof_in;
    chain_q[1] <= chainId_in;
    for (int unsigned k = 2; k <= LOG2N; k++) begin
      op_q[k]    <= op_q[k-1];
      eof_q[k]   <= eof_q[k-1];
      bof_q[k]   <= bof_q[k-1];
      chain_q[k] <= chain_q[k-1];
    end
  end

  // Beat-valid shift register; reset flushes in-flight beats
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 1; k <= LOG2N; k++) valid_q[k] <= 1'b0;
    end else begin
      valid_q[1] <= accept;
      for (int unsigned k = 2; k <= LOG2N; k++) valid_q[k] <= valid_q[k-1];
    end
  end

  // Output formatting and frame accumulation for the beat leaving the tree
  always_comb begin
    acc_next = (bof_q[LOG2N][0] ? '0 : acc) + lvl[LOG2N][0];
    result   = '0;
    emit     = valid_q[LOG2N];
    case (op_q[LOG2N])
      OP_BYPASS: result = lvl[LOG2N];
      OP_FRAME: begin
        result[0] = acc_next;
        emit      = valid_q[LOG2N] & eof_q[LOG2N][0];
      end
      default:   result[0] = lvl[LOG2N][0];
    endcase
  end

  // Output register and shared frame accumulator; outputs hold between beats
  always_ff @(posedge clk) begin
    if (reset) begin
      vector_out  <= '0;
      valid_out   <= 1'b0;
      eof_out     <= '0;
      bof_out     <= '0;
      chainId_out <= '0;
      acc         <= '0;
    end else begin
      valid_out <= emit;
      if (emit) begin
        vector_out  <= result;
        eof_out     <= eof_q[LOG2N];
        bof_out     <= bof_q[LOG2N];
        chainId_out <= chain_q[LOG2N];
      end
      if (valid_q[LOG2N] && op_q[LOG2N] == OP_FRAME) acc <= acc_next;
    end
  end

  // Firmware loader: sequential bytes while addressed, counter saturates
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned c = 0; c < MAX_CHAINS; c++)
        firmware_op[c] <= INITIAL_FIRMWARE_OP[8*c +: 8];
      byte_counter <= '0;
    end else if (!tracing) begin
      if (configId == PERSONAL_CONFIG_ID) begin
        if (byte_counter < CHAIN_LIMIT) begin
          firmware_op[byte_counter[CW-1:0]] <= configData;
          byte_counter <= byte_counter + 1'b1;
        end
      end else begin
        byte_counter <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vector_scalar_reduce.sv
// Bench for vector_scalar_reduce: directed test-plan steps followed by random
// traffic, checked every cycle against an arithmetic reference model. Two
// instances (unsigned and signed max) share all inputs.
module tb_vector_scalar_reduce;

  localparam int N  = 8;
  localparam int DW = 32;
  localparam int MC = 4;
  localparam int CW = 2;
  localparam int L  = 4;
  localparam logic [8*MC-1:0] INIT_FW = 32'h0000_0001;

  typedef logic [N-1:0][DW-1:0] vec_t;

  logic          clk = 1'b0;
  logic          reset, tracing, valid_in;
  logic [1:0]    eof_in, bof_in;
  logic [CW-1:0] chain_in;
  logic [7:0]    config_id, config_data;
  vec_t          vector_in;

  vec_t          vout_u, vout_s;
  logic          vv_u, vv_s;
  logic [1:0]    eo_u, eo_s, bo_u, bo_s;
  logic [CW-1:0] ch_u, ch_s;

  always #5 clk = ~clk;

  vector_scalar_reduce #(
    .N(N), .DATA_WIDTH(DW), .MAX_CHAINS(MC), .PERSONAL_CONFIG_ID(8'd0),
    .DATA_TYPE(0), .INITIAL_FIRMWARE_OP(INIT_FW)
  ) u_dut_u (
    .clk(clk), .reset(reset), .tracing(tracing), .valid_in(valid_in),
    .eof_in(eof_in), .bof_in(bof_in), .chainId_in(chain_in),
    .configId(config_id), .configData(config_data), .vector_in(vector_in),
    .vector_out(vout_u), .valid_out(vv_u), .eof_out(eo_u), .bof_out(bo_u),
    .chainId_out(ch_u)
  );

  vector_scalar_reduce #(
    .N(N), .DATA_WIDTH(DW), .MAX_CHAINS(MC), .PERSONAL_CONFIG_ID(8'd0),
    .DATA_TYPE(1), .INITIAL_FIRMWARE_OP(INIT_FW)
  ) u_dut_s (
    .clk(clk), .reset(reset), .tracing(tracing), .valid_in(valid_in),
    .eof_in(eof_in), .bof_in(bof_in), .chainId_in(chain_in),
    .configId(config_id), .configData(config_data), .vector_in(vector_in),
    .vector_out(vout_s), .valid_out(vv_s), .eof_out(eo_s), .bof_out(bo_s),
    .chainId_out(ch_s)
  );

  int tests = 0;
  int fails = 0;
  int vcount = 0;
  int unsigned cyc = 0;

  // Reference model state
  logic [7:0]    fw [MC];
  int unsigned   bcnt;
  logic [DW-1:0] acc;
  bit            exp_v   [16];
  vec_t          exp_u   [16];
  vec_t          exp_s   [16];
  logic [1:0]    exp_eof [16];
  logic [1:0]    exp_bof [16];
  logic [CW-1:0] exp_ch  [16];
  vec_t          last_u, last_s;

  task automatic chk(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_beat();
    logic [DW-1:0] sum, mu, ms;
    logic [7:0]    opb;
    int unsigned   slot;
    sum = '0;
    mu  = vector_in[0];
    ms  = vector_in[0];
    for (int i = 0; i < N; i++) begin
      sum += vector_in[i];
      if (vector_in[i] > mu) mu = vector_in[i];
      if ($signed(vector_in[i]) > $signed(ms)) ms = vector_in[i];
    end
    opb  = fw[chain_in];
    slot = (cyc + L) % 16;
    exp_v[slot]   = 1'b1;
    exp_eof[slot] = eof_in;
    exp_bof[slot] = bof_in;
    exp_ch[slot]  = chain_in;
    exp_u[slot]   = '0;
    exp_s[slot]   = '0;
    case (opb)
      8'd1: begin exp_u[slot][0] = sum; exp_s[slot][0] = sum; end
      8'd2: begin exp_u[slot][0] = mu;  exp_s[slot][0] = ms;  end
      8'd3: begin
        acc = (bof_in[0] ? '0 : acc) + sum;
        exp_u[slot][0] = acc;
        exp_s[slot][0] = acc;
        exp_v[slot]    = eof_in[0];
      end
      default: begin exp_u[slot] = vector_in; exp_s[slot] = vector_in; end
    endcase
  endtask

  // One clock: model the edge, then check both instances just after it
  task automatic tick();
    int unsigned slot;
    bit was_reset;
    was_reset = reset;
    if (reset) begin
      foreach (exp_v[i]) exp_v[i] = 1'b0;
      acc  = '0;
      bcnt = 0;
      for (int c = 0; c < MC; c++) fw[c] = INIT_FW[8*c +: 8];
    end else if (tracing) begin
      if (valid_in) model_beat();
    end else if (config_id == 8'd0) begin
      if (bcnt < MC) begin
        fw[bcnt] = config_data;
        bcnt++;
      end
    end else begin
      bcnt = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
    slot = cyc % 16;
    if (vv_u === 1'b1) vcount++;
    if (was_reset) begin
      last_u = '0;
      last_s = '0;
      chk("rst_eof", eo_u, 2'b00);
      chk("rst_bof", bo_u, 2'b00);
      chk("rst_chain", ch_u, '0);
      chk("rst_chain_s", ch_s, '0);
    end
    if (exp_v[slot]) begin
      chk("valid_u", vv_u, 1'b1);
      chk("valid_s", vv_s, 1'b1);
      chk("vec_u", vout_u, exp_u[slot]);
      chk("vec_s", vout_s, exp_s[slot]);
      chk("eof_u", eo_u, exp_eof[slot]);
      chk("bof_u", bo_u, exp_bof[slot]);
      chk("chain_u", ch_u, exp_ch[slot]);
      chk("eof_s", eo_s, exp_eof[slot]);
      chk("bof_s", bo_s, exp_bof[slot]);
      chk("chain_s", ch_s, exp_ch[slot]);
      last_u = exp_u[slot];
      last_s = exp_s[slot];
      exp_v[slot] = 1'b0;
    end else begin
      chk("idle_valid_u", vv_u, 1'b0);
      chk("idle_valid_s", vv_s, 1'b0);
      chk("hold_vec_u", vout_u, last_u);
      chk("hold_vec_s", vout_s, last_s);
    end
  endtask

  task automatic idle(input int n);
    reset = 1'b0; tracing = 1'b1; valid_in = 1'b0; config_id = 8'h55;
    repeat (n) tick();
  endtask

  task automatic beat(input logic [CW-1:0] ch, input vec_t v, input logic [1:0] b, input logic [1:0] e);
    reset = 1'b0; tracing = 1'b1; valid_in = 1'b1; config_id = 8'h55;
    chain_in = ch; vector_in = v; bof_in = b; eof_in = e;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic cfg(input logic [7:0] d);
    reset = 1'b0; tracing = 1'b0; valid_in = 1'b0; config_id = 8'd0; config_data = d;
    tick();
  endtask

  task automatic cfg_gap();
    reset = 1'b0; tracing = 1'b0; valid_in = 1'b0; config_id = 8'h55;
    tick();
  endtask

  task automatic lane0(input string tag, input logic [DW-1:0] val_u, input logic [DW-1:0] val_s);
    vec_t e;
    e = '0;
    e[0] = val_u;
    chk({tag, "_valid"}, vv_u, 1'b1);
    chk(tag, vout_u, e);
    e[0] = val_s;
    chk({tag, "_s"}, vout_s, e);
  endtask

  function automatic vec_t fill(input logic [DW-1:0] x);
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = x;
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < N; i++)
      v[i] = ($urandom_range(0, 1) == 1) ? $urandom : DW'($urandom_range(0, 15));
    return v;
  endfunction

  initial begin
    vec_t v;
    int   sl [N];
    reset = 1'b1; tracing = 1'b0; valid_in = 1'b0; eof_in = '0; bof_in = '0;
    chain_in = '0; config_id = 8'h55; config_data = '0; vector_in = '0;
    repeat (3) tick();

    // Chain 0 starts as sum: lanes 1..8
    for (int i = 0; i < N; i++) v[i] = DW'(i + 1);
    beat(2'd0, v, 2'b00, 2'b00);
    idle(3);
    lane0("sum_1to8", 36, 36);

    // Firmware: chain0 max, chain1 sum, chain2 bypass, chain3 frame sum
    cfg_gap();
    cfg(8'd2); cfg(8'd1); cfg(8'd0); cfg(8'd3);
    v = '0;
    v[0] = 5; v[1] = 200; v[2] = 7; v[7] = 1;
    beat(2'd0, v, 2'b00, 2'b00); idle(3);
    lane0("max_u", 200, 200);
    beat(2'd1, v, 2'b00, 2'b00); idle(3);
    lane0("sum_213", 213, 213);
    beat(2'd2, v, 2'b10, 2'b01); idle(3);
    chk("bypass_vec", vout_u, v);

    // Signed max and wrapping sum
    sl = '{-3, -1, -7, -2, -9, -4, -5, -6};
    for (int i = 0; i < N; i++) v[i] = DW'(sl[i]);
    beat(2'd0, v, 2'b00, 2'b00); idle(3);
    lane0("max_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    beat(2'd1, fill(32'hFFFF_FFFF), 2'b00, 2'b00); idle(3);
    lane0("sum_wrap", 32'hFFFF_FFF8, 32'hFFFF_FFF8);

    // Frame sum over three beats, then a single-beat frame
    beat(2'd3, fill(1), 2'b01, 2'b00);
    chk("frame_mid_novalid", vv_u, 1'b0);
    beat(2'd3, fill(1), 2'b00, 2'b00);
    beat(2'd3, fill(1), 2'b00, 2'b01);
    idle(3);
    lane0("frame_24", 24, 24);
    beat(2'd3, fill(2), 2'b01, 2'b01); idle(3);
    lane0("frame_single", 16, 16);

    // Back-to-back alternating chains
    vcount = 0;
    for (int i = 0; i < 8; i++)
      beat((i % 2 == 0) ? 2'd1 : 2'd2, rand_vec(), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    idle(4);
    chk("b2b_count", 32'(vcount), 32'd8);

    // Reset mid-flight: pending beats and accumulator are discarded
    beat(2'd3, fill(1), 2'b01, 2'b00);
    beat(2'd1, rand_vec(), 2'b00, 2'b00);
    beat(2'd2, rand_vec(), 2'b00, 2'b00);
    reset = 1'b1; valid_in = 1'b1; tracing = 1'b1;
    tick();
    vcount = 0;
    idle(6);
    chk("flush_none", 32'(vcount), 32'd0);
    cfg_gap();
    cfg(8'd2); cfg(8'd1); cfg(8'd0); cfg(8'd3);
    beat(2'd3, fill(3), 2'b00, 2'b01); idle(3);
    lane0("acc_after_reset", 24, 24);

    // Beats are ignored in config mode
    reset = 1'b0; tracing = 1'b0; valid_in = 1'b1; config_id = 8'h55;
    vcount = 0;
    repeat (L + 1) tick();
    chk("config_mode_novalid", 32'(vcount), 32'd0);

    // Fifth config byte is dropped, chain 0 stays sum
    cfg_gap();
    cfg(8'd1); cfg(8'd2); cfg(8'd2); cfg(8'd1); cfg(8'd2);
    for (int i = 0; i < N; i++) v[i] = DW'(i + 1);
    beat(2'd0, v, 2'b00, 2'b00); idle(3);
    lane0("fifth_ignored", 36, 36);

    // Random traffic including config bursts and occasional reset
    for (int n = 0; n < 400; n++) begin
      reset       = ($urandom_range(0, 99) == 0);
      tracing     = ($urandom_range(0, 9) != 0);
      valid_in    = ($urandom_range(0, 3) != 0);
      config_id   = ($urandom_range(0, 1) == 1) ? 8'd0 : 8'h21;
      config_data = 8'($urandom_range(0, 5));
      chain_in    = CW'($urandom_range(0, MC - 1));
      eof_in      = 2'($urandom_range(0, 3));
      bof_in      = 2'($urandom_range(0, 3));
      vector_in   = rand_vec();
      tick();
    end
    idle(6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vector_scalar_reduce.md
Name: vector_scalar_reduce

Overview:
- Sits directly downstream of vectorVectorALU and consumes its vector_out, valid_out, eof_out, bof_out and chainId_out.
- Reduces each N-lane vector to one scalar using a pipelined per-chain firmware op: bypass, sum, max, or frame-accumulated sum.
- The scalar is emitted in lane 0 of an N-lane output bus, so the next stage keeps the same vector interface.
- Firmware is loaded over the shared configId/configData byte stream.

Parameters:
- N, 8: lanes per vector; must be a power of 2 and at least 2.
- DATA_WIDTH, 32: bits per lane.
- MAX_CHAINS, 4: number of firmware chains.
- PERSONAL_CONFIG_ID, 0: configId value that addresses this block.
- DATA_TYPE, 0: 0 means unsigned integer; 1 means signed two's-complement fixed point.
- INITIAL_FIRMWARE_OP, all 0: per-chain op reset value (8 bits per chain).

Ports:
- clk  in  1  clock; all logic is on posedge.
- reset  in  1  synchronous, active-high reset.
- tracing  in  1  1 means trace mode; 0 means config mode.
- valid_in  in  1  input beat valid.
- eof_in  in  2  end-of-frame flags; [0] inner, [1] outer.
- bof_in  in  2  begin-of-frame flags; [0] inner, [1] outer.
- chainId_in  in  $clog2(MAX_CHAINS)  firmware chain select.
- configId  in  8  config target id.
- configData  in  8  config byte.
- vector_in  in  DATA_WIDTH x N  input lanes.
- vector_out  out  DATA_WIDTH x N  result; lane 0 is the scalar, other lanes 0 (except bypass).
- valid_out  out  1  output beat valid.
- eof_out  out  2  eof_in delayed to align with the output.
- bof_out  out  2  bof_in delayed to align with the output.
- chainId_out  out  $clog2(MAX_CHAINS)  chainId_in delayed to align with the output.

Behaviour:
- Reset:
  - Synchronous, active-high.
  - Clears every output to 0, all pipeline valids, the accumulator, and byte_counter.
  - Reloads firmware_op from INITIAL_FIRMWARE_OP.
  - Reset mid-operation flushes in-flight beats; no output is produced for them.
- Op selection:
  - An op is latched per beat from firmware_op[chainId_in] at stage 0.
  - Ops: 0 bypass, 1 sum, 2 max, 3 frame sum, other values treated as 0.
- Beat acceptance: a beat enters the pipeline only when valid_in & tracing is 1.
- Pipeline:
  - Stages 1..log2(N) are registered pairwise tree levels, each level halving the lane count.
  - Final stage (the output register) applies the accumulator and output formatting.
  - Fixed latency L = log2(N)+1 cycles from valid_in to valid_out; L = 4 for N=8.
  - Fully pipelined: one beat per cycle; no backpressure.
  - eof, bof and chainId are carried through the pipeline alongside the data.
  - Bypass vectors are delayed by the same L cycles.
- Sum:
  - Modulo 2^DATA_WIDTH; overflow wraps.
  - Adds are identical for both DATA_TYPE values.
- Max:
  - DATA_TYPE=0: unsigned compare.
  - DATA_TYPE=1: signed compare using the MSB (bit DATA_WIDTH-1) as sign.
  - Ties select the lower lane; the value is the same either way.
- Frame sum (op 3):
  - On an accepted beat: acc <= (bof[0] ? 0 : acc) + tree_sum.
  - valid_out is asserted only when eof[0]=1; lane 0 then carries the new acc value.
  - Non-eof beats produce valid_out=0.
  - A beat with both bof[0] and eof[0] set outputs its own tree_sum.
  - A single accumulator is shared by all chains, and it wraps.
- Outputs:
  - When valid_out=0, vector_out holds its last value.
  - When tracing drops, already-accepted beats still drain.
- Config (tracing=0):
  - While configId==PERSONAL_CONFIG_ID, each cycle writes firmware_op[byte_counter] <= configData and increments byte_counter.
  - Bytes with byte_counter >= MAX_CHAINS are ignored; the counter saturates at MAX_CHAINS.
  - When configId differs, byte_counter <= 0.
  - Config mode is ignored while tracing=1.

Test Plan:
- Reset, then trace chain 0 (op 1) with vector_in=1..8 and valid_in=1 → 4 cycles later valid_out=1, lane0=36, lanes 1-7=0; all outputs are 0 during reset.
- Config with tracing=0, configId=0, data bytes 2,1,0,3; then vector {5,200,7,0,0,0,0,1} on chain 0, DATA_TYPE=0 → lane0=200. Same bytes on chain 1 → lane0=213. Chain 2 (bypass) → vector returned unchanged after 4 cycles.
- DATA_TYPE=1, op 2, lanes {-3,-1,-7,-2,-9,-4,-5,-6} (32-bit two's complement) → lane0=0xFFFFFFFF. Sum of eight 0xFFFFFFFF lanes → lane0=0xFFFFFFF8 (wrap).
- Op 3, three beats each with all lanes=1: bof=01, then 00, then eof=01 → only the third beat gives valid_out=1, lane0=24. A following single beat with bof=eof=01 and all lanes=2 → lane0=16.
- Back-to-back valid_in on 8 consecutive cycles with alternating chains 1 and 2 → 8 consecutive valid_out cycles with matching chainId_out, eof_out and bof_out. Assert reset on cycle 3 → no further valid_out, and the accumulator reads 0 on the next op-3 frame.
- tracing=0 with valid_in=1 → no valid_out. Five config bytes with MAX_CHAINS=4 → the fifth byte is ignored and firmware_op[0] is unchanged.
